// File: rtl/config_loader_pkg.sv
// Shared constants and state type for the
// configuration frame loader.
package config_loader_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam logic [7:0]  OP_FRAME  = 8'h00;
  localparam logic [7:0]  OP_END    = 8'hFF;

  typedef enum logic [1:0] {
    HUNT,
    ADDR,
    DATA,
    STROBE
  } loaderState_t;

endpackage

// File: rtl/config_frame_loader_strobe.sv
// Maps (column, frame) to a one-hot frame latch
// strobe and flags addresses outside the fabric.
module config_strobe_decoder
  import config_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 8
) (
  input  logic [7:0] column,
  input  logic [4:0] frame,
  input  logic       enable,
  output logic [MaxFramesPerCol*NumColumns-1:0] frameStrobe,
  output logic       rangeError
);

  localparam int StrobeW = MaxFramesPerCol * NumColumns;

  logic [31:0] bitIdx;

  // Range check and one-hot decode of the flat bit index
  always_comb begin
    rangeError = (32'(column) >= 32'(NumColumns))
              || (32'(frame) >= 32'(MaxFramesPerCol));
    bitIdx = 32'(column) * 32'(MaxFramesPerCol)
           + 32'(frame);
    frameStrobe = '0;
    for (int i = 0; i < StrobeW; i++) begin
      frameStrobe[i] = enable && !rangeError
                    && (bitIdx == 32'(i));
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream word loader: hunts for sync, decodes
// frame addresses, gathers row data, fires strobes.
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 8
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [31:0] WriteData,
  input  logic        WriteStrobe,
  output logic        WriteReady,
  output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
  output logic        ConfigActive,
  output logic        ConfigError
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  loaderState_t state;
  loaderState_t nextState;

  logic [7:0]      column;
  logic [4:0]      frame;
  logic [RowW-1:0] rowCnt;
  logic            accept;
  logic            lastRow;
  logic            isSync;
  logic            strobeEn;
  logic            rangeError;

  assign accept  = WriteStrobe && WriteReady;
  assign lastRow = (rowCnt == RowW'(NumRows - 1));
  assign isSync  = (WriteData == SYNC_WORD);

  // State register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= HUNT;
    else         state <= nextState;
  end

  // Next-state decision on each accepted word
  always_comb begin
    nextState = state;
    unique case (state)
      HUNT: begin
        if (accept && isSync) nextState = ADDR;
      end
      ADDR: begin
        if (accept) begin
          if (WriteData[31:24] == OP_END)
            nextState = HUNT;
          else if (WriteData[31:24] == OP_FRAME)
            nextState = DATA;
        end
      end
      DATA: begin
        if (accept && lastRow) nextState = STROBE;
      end
      STROBE: nextState = ADDR;
      default: nextState = HUNT;
    endcase
  end

  // Handshake and status outputs from state
  always_comb begin
    WriteReady   = (state != STROBE);
    ConfigActive = (state != HUNT);
    strobeEn     = (state == STROBE);
  end

  // Address latch and row data capture
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      column    <= '0;
      frame     <= '0;
      rowCnt    <= '0;
      FrameData <= '0;
    end else if (accept) begin
      if (state == ADDR
          && WriteData[31:24] == OP_FRAME) begin
        column <= WriteData[15:8];
        frame  <= WriteData[4:0];
        rowCnt <= '0;
      end
      if (state == DATA) begin
        for (int r = 0; r < NumRows; r++) begin
          if (rowCnt == RowW'(r))
            FrameData[r*FrameBitsPerRow +: FrameBitsPerRow]
              <= WriteData[FrameBitsPerRow-1:0];
        end
        rowCnt <= lastRow ? '0 : rowCnt + RowW'(1);
      end
    end
  end

  // Sticky range error, cleared by a fresh sync
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)
      ConfigError <= 1'b0;
    else if (accept && state == HUNT && isSync)
      ConfigError <= 1'b0;
    else if (strobeEn && rangeError)
      ConfigError <= 1'b1;
  end

  config_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumColumns     (NumColumns)
  ) uDecoder (
    .column     (column),
    .frame      (frame),
    .enable     (strobeEn),
    .frameStrobe(FrameStrobe),
    .rangeError (rangeError)
  );

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed plus randomized frame-load checks
// against a transaction-level expectation model.
module tb_config_frame_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic         CLK = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  WriteData = '0;
  logic         WriteStrobe = 1'b0;
  logic         WriteReady;
  logic [127:0] FrameData;
  logic [159:0] FrameStrobe;
  logic         ConfigActive;
  logic         ConfigError;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] expData [4];
  bit          expErr = 0;
  bit          expActive = 0;

  config_frame_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .WriteReady  (WriteReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ConfigActive(ConfigActive),
    .ConfigError (ConfigError)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [159:0] obs,
                       input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h required=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] packed_exp();
    return {expData[3], expData[2],
            expData[1], expData[0]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) expData[i] = '0;
    expErr = 0;
    expActive = 0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_strobe"}, FrameStrobe, '0);
    check({tag, "_ready"}, 160'(WriteReady), 160'(1));
    check({tag, "_active"}, 160'(ConfigActive),
          160'(expActive));
    check({tag, "_err"}, 160'(ConfigError), 160'(expErr));
  endtask

  task automatic sendWord(input logic [31:0] w);
    int n = 0;
    while (WriteReady !== 1'b1 && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n == 10) check("ready_timeout", 160'(WriteReady), 160'(1));
    WriteData = w;
    WriteStrobe = 1'b1;
    @(posedge CLK); #1;
    WriteStrobe = 1'b0;
    WriteData = $urandom;
  endtask

  task automatic syncUp(input string tag);
    sendWord(SYNC);
    expActive = 1;
    expErr = 0;
    checkIdle(tag);
  endtask

  function automatic logic [31:0] pickData();
    int r = $urandom_range(0, 3);
    if (r == 0) return SYNC;
    if (r == 1) return {8'hFF, 24'($urandom)};
    return $urandom;
  endfunction

  function automatic logic [31:0] junkWord();
    logic [31:0] w = $urandom;
    if (w == SYNC) w = w ^ 32'h1;
    return w;
  endfunction

  // One frame write; stallAt names the word index
  // preceded by stallLen idle cycles (>=4 = none).
  task automatic doFrame(input string tag,
                         input logic [7:0] col,
                         input logic [4:0] frm,
                         input logic [31:0] d [4],
                         input int stallAt,
                         input int stallLen,
                         input bit rstInStrobe);
    logic [159:0] expStrobe;
    bit bad;
    bad = (col >= 8) || (frm >= 20);
    sendWord({8'h00, 8'($urandom), col,
              3'($urandom), frm});
    for (int k = 0; k < 4; k++) begin
      if (k == stallAt) begin
        for (int s = 0; s < stallLen; s++) begin
          @(posedge CLK); #1;
          check({tag, "_stall_strobe"}, FrameStrobe, '0);
          if (!bad)
            check({tag, "_stall_data"}, 160'(FrameData),
                  160'(packed_exp()));
        end
      end
      sendWord(d[k]);
      expData[k] = d[k];
      if (k < 3) check({tag, "_mid_strobe"}, FrameStrobe, '0);
    end
    expStrobe = bad ? '0
              : (160'(1) << (int'(col) * 20 + int'(frm)));
    if (bad) expErr = 1;
    check({tag, "_strobe"}, FrameStrobe, expStrobe);
    check({tag, "_ready_low"}, 160'(WriteReady), 160'(0));
    if (!bad)
      check({tag, "_data"}, 160'(FrameData),
            160'(packed_exp()));
    if (rstInStrobe) begin
      resetn = 1'b0;
      #1;
      modelReset();
      check({tag, "_rst_strobe"}, FrameStrobe, '0);
      check({tag, "_rst_data"}, 160'(FrameData), '0);
      checkIdle({tag, "_rst"});
      @(posedge CLK); #1;
      resetn = 1'b1;
      return;
    end
    @(posedge CLK); #1;
    checkIdle({tag, "_after"});
    if (!bad)
      check({tag, "_hold"}, 160'(FrameData),
            160'(packed_exp()));
  endtask

  logic [31:0] d [4];
  logic [127:0] snap;

  initial begin
    modelReset();
    #3;
    check("rst_data", 160'(FrameData), '0);
    checkIdle("rst");
    repeat (2) @(posedge CLK);
    #1;
    resetn = 1'b1;
    @(posedge CLK); #1;
    checkIdle("post_rst");

    // Junk before sync, then frame at column 2 frame 3
    sendWord(32'h1234_5678);
    checkIdle("junk");
    syncUp("sync1");
    d = '{32'hA0A0_0001, 32'hB1B1_0002,
          32'hC2C2_0003, 32'hD3D3_0004};
    sendWord(32'h0000_0203);
    for (int k = 0; k < 4; k++) begin
      sendWord(d[k]);
      expData[k] = d[k];
    end
    check("f43_strobe", FrameStrobe, 160'(1) << 43);
    check("f43_ready", 160'(WriteReady), 160'(0));
    check("f43_data", 160'(FrameData),
          160'({d[3], d[2], d[1], d[0]}));
    @(posedge CLK); #1;
    checkIdle("f43_after");

    // Sync word and end opcode inside data
    d = '{SYNC, 32'hFF00_0000, SYNC, 32'h5555_AAAA};
    doFrame("indata", 8'd7, 5'd19, d, 9, 0, 0);

    // Stall between D1 and D2
    d = '{32'h1111_1111, 32'h2222_2222,
          32'h3333_3333, 32'h4444_4444};
    doFrame("stall", 8'd0, 5'd0, d, 2, 5, 0);

    // Ignored opcode in ADDR
    sendWord(32'h4200_0305);
    checkIdle("badop");

    // Column out of range, error sticky
    d = '{32'hDEAD_0000, 32'hDEAD_0001,
          32'hDEAD_0002, 32'hDEAD_0003};
    sendWord(32'h0000_0813);
    for (int k = 0; k < 4; k++) begin
      sendWord(d[k]);
      check("col8_strobe", FrameStrobe, '0);
    end
    expErr = 1;
    @(posedge CLK); #1;
    checkIdle("col8_after");
    d = '{32'h0, 32'h1, 32'h2, 32'h3};
    doFrame("post_err", 8'd1, 5'd1, d, 9, 0, 0);

    // End command then ignored traffic
    sendWord(32'hFF00_0000);
    expActive = 0;
    checkIdle("end");
    snap = FrameData;
    sendWord(32'h0000_0203);
    for (int k = 0; k < 4; k++) begin
      sendWord(junkWord());
      checkIdle("hunt_junk");
    end
    check("hunt_hold", 160'(FrameData), 160'(snap));
    syncUp("sync2");

    // Reset after D2
    sendWord(32'h0000_0101);
    for (int k = 0; k < 3; k++) sendWord($urandom);
    resetn = 1'b0;
    #1;
    modelReset();
    check("midrst_data", 160'(FrameData), '0);
    checkIdle("midrst");
    @(posedge CLK); #1;
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      checkIdle("midrst_quiet");
    end
    syncUp("sync3");
    d = '{32'hCAFE_0000, 32'hCAFE_0001,
          32'hCAFE_0002, 32'hCAFE_0003};
    doFrame("reload", 8'd3, 5'd10, d, 9, 0, 0);

    // Reset during the strobe cycle
    doFrame("rststb", 8'd4, 5'd4, d, 9, 0, 1);
    @(posedge CLK); #1;
    checkIdle("rststb_quiet");
    syncUp("sync4");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) begin
        sendWord({8'($urandom_range(1, 254)),
                  24'($urandom)});
        checkIdle("rnd_badop");
      end else if (r == 1) begin
        sendWord({8'hFF, 24'($urandom)});
        expActive = 0;
        checkIdle("rnd_end");
        snap = FrameData;
        sendWord(junkWord());
        sendWord(32'h0000_0000);
        checkIdle("rnd_hunt");
        check("rnd_hunt_hold", 160'(FrameData),
              160'(snap));
        syncUp("rnd_sync");
      end else begin
        for (int k = 0; k < 4; k++) d[k] = pickData();
        doFrame("rnd", 8'($urandom_range(0, 9)),
                5'($urandom_range(0, 23)), d,
                $urandom_range(0, 6),
                $urandom_range(1, 6), 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, bits per row frame register; only 32 is legal.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, frames per tile column.
REQ-003 SHALL have parameter NumRows, default 4, tile rows fed by FrameData.
REQ-004 SHALL have parameter NumColumns, default 8, tile columns fed by FrameStrobe.
REQ-005 SHALL have port CLK input 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port WriteData input 32: bitstream word.
REQ-008 SHALL have port WriteStrobe input 1: WriteData valid.
REQ-009 SHALL have port WriteReady output 1: word accepted when WriteStrobe and WriteReady are both high on a rising edge.
REQ-010 SHALL have port FrameData output FrameBitsPerRow*NumRows: row frame data to the tile config memories.
REQ-011 SHALL have port FrameStrobe output MaxFramesPerCol*NumColumns: one-hot frame latch strobe.
REQ-012 SHALL have port ConfigActive output 1: high between sync and end command.
REQ-013 SHALL have port ConfigError output 1: sticky address-range error.

Function
REQ-014 SHALL implement states HUNT, ADDR, DATA, STROBE.
REQ-015 In HUNT, accepted words other than 32'hFAB0_FAB1 SHALL be discarded; the sync word SHALL move to ADDR and set ConfigActive.
REQ-016 In ADDR, an accepted word with [31:24]=8'hFF SHALL return to HUNT and clear ConfigActive.
REQ-017 In ADDR, [31:24]=8'h00 SHALL latch column=[15:8] and frame=[4:0], clear the row counter and go to DATA.
REQ-018 In ADDR, any other opcode SHALL be ignored; state stays ADDR.
REQ-019 In DATA, the k-th accepted word (k=0..NumRows-1) SHALL be written to FrameData[32k+31:32k]; after word NumRows-1 the FSM SHALL go to STROBE.
REQ-020 In DATA, the sync word and 8'hFF opcodes SHALL be treated as ordinary data.
REQ-021 In STROBE, for exactly one cycle, FrameStrobe bit column*MaxFramesPerCol+frame SHALL be high and all other bits low, with FrameData stable; the FSM then returns to ADDR.
REQ-022 WriteReady SHALL be low in STROBE and high in all other states.
REQ-023 If column>=NumColumns or frame>=MaxFramesPerCol, the data words SHALL still be consumed, FrameStrobe SHALL stay all-zero in STROBE, and ConfigError SHALL set.
REQ-024 ConfigError SHALL clear only on reset or on acceptance of a sync word in HUNT.
REQ-025 FrameData SHALL hold its last value outside DATA; FrameStrobe SHALL be zero outside STROBE.
REQ-026 Cycles with WriteStrobe low SHALL cause no state or data change, including mid-DATA stalls of any length.
REQ-027 Minimum latency from acceptance of the last data word to the strobe SHALL be one cycle.

Reset
REQ-028 When resetn is low, the state SHALL be HUNT; FrameData, FrameStrobe, ConfigActive, ConfigError and the row counter SHALL be 0; WriteReady SHALL be 1.
REQ-029 Reset asserted mid-frame or during STROBE SHALL abort immediately with no further strobe pulse.

Structure
REQ-030 Package config_loader_pkg SHALL hold the sync constant, opcode constants (OP_FRAME=8'h00, OP_END=8'hFF) and the state enum.
REQ-031 One sub-module, config_strobe_decoder, SHALL map (column, frame, enable) to the one-hot FrameStrobe with range checking, outputting a range-error flag.

Verification
REQ-032 Words 0x1234_5678, 0xFAB0_FAB1, 0x0000_0203, D0..D3 -> first word ignored; FrameData = {D3,D2,D1,D0}; FrameStrobe bit 43 high for 1 cycle; WriteReady low in that cycle.
REQ-033 After sync, address 0x0000_0813 (column 8) plus 4 data words -> FrameStrobe stays 0; ConfigError=1 until the next sync.
REQ-034 Frame write with WriteStrobe low for 5 cycles between D1 and D2 -> identical FrameData and a single strobe.
REQ-035 Data word 0xFAB0_FAB1 in DATA -> stored as data; FSM does not resync.
REQ-036 resetn pulsed low after D2 -> no strobe; all outputs 0, WriteReady 1; a fresh sync sequence then loads correctly.
REQ-037 Address 0xFF00_0000 after a frame -> ConfigActive falls; later words ignored until sync.
